// File: rtl/image_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : image_frame_buffer
// Description : Single-frame RGB image store shared with the process block.
//               Loads a raster-order pixel stream, lets the process block
//               read and modify pixels in place, then streams the frame out.
// Revision    : 1.0 - initial release
// ============================================================================
module image_frame_buffer #(
  parameter int ADDR_W = 6,
  parameter int PIX_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  // input pixel stream
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_pix,
  output logic              s_ready,
  // process block access
  input  logic [ADDR_W-1:0] row,
  input  logic [ADDR_W-1:0] col,
  output logic [PIX_W-1:0]  in_pix,
  input  logic              out_we,
  input  logic [PIX_W-1:0]  out_pix,
  output logic              proc_start,
  input  logic              proc_done,
  // output pixel stream
  output logic              m_valid,
  output logic [PIX_W-1:0]  m_pix,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int              C_AW      = 2 * ADDR_W;
  localparam int              C_DEPTH   = 1 << C_AW;
  localparam logic [C_AW-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [C_AW-1:0] load_cnt_q, load_cnt_d;
  logic [C_AW-1:0] dump_cnt_q, dump_cnt_d;

  // Pixel storage; deliberately not reset, a frame is always reloaded first.
  logic [PIX_W-1:0] mem [C_DEPTH];

  logic             w_mem_we;
  logic [C_AW-1:0]  w_mem_waddr;
  logic [PIX_W-1:0] w_mem_wdata;
  logic             w_s_hs;
  logic             w_m_hs;

  // Stream handshakes and outputs, all decoded from the current state.
  always_comb begin
    s_ready    = (state_q == ST_LOAD);
    proc_start = (state_q == ST_RUN);
    m_valid    = (state_q == ST_DUMP);
    m_last     = (state_q == ST_DUMP) && (dump_cnt_q == C_CNT_MAX);
    w_s_hs     = s_valid && s_ready;
    w_m_hs     = m_valid && m_ready;
    // Both reads are asynchronous: the write only lands at the clock edge,
    // so in_pix shows the pre-write value during a write cycle.
    in_pix     = mem[{row, col}];
    m_pix      = mem[dump_cnt_q];
  end

  // Single write port shared between the loader and the process block.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = load_cnt_q;
    w_mem_wdata = s_pix;
    case (state_q)
      ST_LOAD: w_mem_we = w_s_hs;
      ST_RUN: begin
        w_mem_we    = out_we;
        w_mem_waddr = {row, col};
        w_mem_wdata = out_pix;
      end
      default: w_mem_we = 1'b0;
    endcase
    // An aborted cycle must not leave a stray write behind.
    if (rst) begin
      w_mem_we = 1'b0;
    end
  end

  // Memory write.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Next-state and counter logic for the LOAD -> RUN -> DUMP cycle.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    dump_cnt_d = dump_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (w_s_hs) begin
          // Natural wrap of the full-width counter brings it back to 0.
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == C_CNT_MAX) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (proc_done) begin
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (w_m_hs) begin
          dump_cnt_d = dump_cnt_q + 1'b1;
          if (m_last) begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      dump_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      dump_cnt_q <= dump_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_frame_buffer
// Description : Directed self-checking bench for image_frame_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_frame_buffer;

  localparam int ADDR_W = 6;
  localparam int PIX_W  = 24;
  localparam int NPIX   = 4096;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic [PIX_W-1:0]  s_pix;
  logic              s_ready;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [PIX_W-1:0]  in_pix;
  logic              out_we;
  logic [PIX_W-1:0]  out_pix;
  logic              proc_start;
  logic              proc_done;
  logic              m_valid;
  logic [PIX_W-1:0]  m_pix;
  logic              m_last;
  logic              m_ready;

  int checks   = 0;
  int failures = 0;

  image_frame_buffer #(
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_pix     (s_pix),
    .s_ready   (s_ready),
    .row       (row),
    .col       (col),
    .in_pix    (in_pix),
    .out_we    (out_we),
    .out_pix   (out_pix),
    .proc_start(proc_start),
    .proc_done (proc_done),
    .m_valid   (m_valid),
    .m_pix     (m_pix),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame contents expected after the RUN phase: raster address everywhere
  // except the two pixels the process block rewrote.
  function automatic logic [31:0] exp_pix(input int idx);
    if (idx == 327)       return 32'h0000AA00;
    else if (idx == 4095) return 32'h00123456;
    else                  return idx;
  endfunction

  initial begin
    int e;
    int cyc;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_pix     = '0;
    row       = '0;
    col       = '0;
    out_we    = 1'b0;
    out_pix   = '0;
    proc_done = 1'b0;
    m_ready   = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_s_ready",    32'(s_ready),    32'd1);
    check("rst_proc_start", 32'(proc_start), 32'd0);
    check("rst_m_valid",    32'(m_valid),    32'd0);
    check("rst_m_last",     32'(m_last),     32'd0);
    rst = 1'b0;

    // ---- partial garbage frame, then reset mid-LOAD ----
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_pix   = ~PIX_W'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_s_ready",    32'(s_ready),    32'd1);
    check("abort_proc_start", 32'(proc_start), 32'd0);

    // ---- full load; out_we/proc_done held high must have no effect ----
    row       = 6'd0;
    col       = 6'd0;
    out_we    = 1'b1;
    out_pix   = 24'hDEADBE;
    proc_done = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      check("load_s_ready",    32'(s_ready),    32'd1);
      check("load_proc_start", 32'(proc_start), 32'd0);
      s_valid = 1'b1;
      s_pix   = PIX_W'(i);
      @(negedge clk);
    end
    s_valid   = 1'b0;
    out_we    = 1'b0;
    proc_done = 1'b0;
    check("run_proc_start", 32'(proc_start), 32'd1);
    check("run_s_ready",    32'(s_ready),    32'd0);
    check("run_m_valid",    32'(m_valid),    32'd0);

    // ---- RUN: read, read-before-write, write ----
    row = 6'd5;
    col = 6'd7;
    #1;
    check("run_rd_5_7", 32'(in_pix), 32'h000147);
    out_we  = 1'b1;
    out_pix = 24'h00AA00;
    #1;
    check("run_rbw_5_7", 32'(in_pix), 32'h000147);
    @(negedge clk);
    out_we = 1'b0;
    #1;
    check("run_wr_5_7",  32'(in_pix),     32'h00AA00);
    check("run_hold",    32'(proc_start), 32'd1);
    row = 6'd0;
    col = 6'd0;
    #1;
    check("run_rd_0_0", 32'(in_pix), 32'h000000);
    row = 6'd63;
    col = 6'd63;
    #1;
    check("run_rd_63_63", 32'(in_pix), 32'h000FFF);

    // ---- write at (63,63) in the same cycle as proc_done ----
    out_we    = 1'b1;
    out_pix   = 24'h123456;
    proc_done = 1'b1;
    @(negedge clk);
    check("dump_latency_m_valid", 32'(m_valid),    32'd1);
    check("dump_proc_start",      32'(proc_start), 32'd0);
    check("dump_s_ready",         32'(s_ready),    32'd0);

    // ---- DUMP with m_ready toggling; stray inputs must be ignored ----
    row       = 6'd0;
    col       = 6'd0;
    out_we    = 1'b1;
    out_pix   = 24'hBADBAD;
    proc_done = 1'b1;
    s_valid   = 1'b1;
    s_pix     = 24'h777777;
    e   = 0;
    cyc = 0;
    while (e < NPIX && cyc < 20000) begin
      check("dump_m_valid", 32'(m_valid), 32'd1);
      check("dump_m_pix",   32'(m_pix),   exp_pix(e));
      check("dump_m_last",  32'(m_last),  32'(e == NPIX - 1));
      m_ready = cyc[0];
      @(posedge clk);
      if (m_ready) e++;
      @(negedge clk);
      cyc++;
    end
    check("dump_handshakes", 32'(e), 32'(NPIX));
    out_we    = 1'b0;
    proc_done = 1'b0;
    s_valid   = 1'b0;
    m_ready   = 1'b0;
    check("post_s_ready",    32'(s_ready),    32'd1);
    check("post_m_valid",    32'(m_valid),    32'd0);
    check("post_m_last",     32'(m_last),     32'd0);
    check("post_proc_start", 32'(proc_start), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
